// File: rtl/serial_link_pkg.sv
// -----------------------------------------------------------------------------
// serial_link_pkg
//
// Shared definitions for both ends of the 32-bit serial word link.
// The transmitter and the matching receiver import this package so that
// the frame width, bit timing and state encoding cannot drift apart.
//
// Contents:
//   WORD_W_DEF    default bits per frame
//   CLK_DIV_DEF   default clk cycles per bitclk half-period
//   GAP_BITS_DEF  default bit periods of comEn-low between frames
//   tx_state_e    transmitter FSM states
//   tx_dbg_t      transmitter debug/observation bundle
// -----------------------------------------------------------------------------
package serial_link_pkg;

  localparam int WORD_W_DEF   = 32;
  localparam int CLK_DIV_DEF  = 50;
  localparam int GAP_BITS_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } tx_state_e;

  // Observation bundle: current FSM state plus the divider strobes, so an
  // external checker can line up bit boundaries without re-deriving them.
  typedef struct packed {
    tx_state_e state;
    logic      rise_tick;
    logic      fall_tick;
  } tx_dbg_t;

endpackage

// File: rtl/serial_word_transmitter_if.sv
// -----------------------------------------------------------------------------
// serial_word_transmitter_if
//
// Parallel-side request channel of the serial word transmitter.
//
// Handshake: a word moves when txvalid and txready are both high on the same
// rising clk edge. txdata is only looked at on that edge. While txready is
// low, txvalid and txdata are ignored entirely, so the producer may change
// them freely. abort is a plain synchronous strobe, not part of the handshake.
//
// Signals:
//   txdata   [WORD_W-1:0]  word to send          (master -> slave)
//   txvalid                word-available        (master -> slave)
//   txready                word can be accepted  (slave  -> master)
//   abort                  synchronous abort     (master -> slave)
//
// Modports:
//   master  producer side (order/exchange logic, testbench driver)
//   slave   transmitter side
// -----------------------------------------------------------------------------
interface serial_word_transmitter_if #(
  parameter int WORD_W = serial_link_pkg::WORD_W_DEF
) ();

  logic [WORD_W-1:0] txdata;
  logic              txvalid;
  logic              txready;
  logic              abort;

  modport master (
    output txdata,
    output txvalid,
    output abort,
    input  txready
  );

  modport slave (
    input  txdata,
    input  txvalid,
    input  abort,
    output txready
  );

endinterface

// File: rtl/serial_bitclk_gen.sv
// -----------------------------------------------------------------------------
// serial_bitclk_gen
//
// Free-running bit clock generator shared by both ends of the serial link.
// A counter runs 0..CLK_DIV-1 on every clk; on its last count it wraps and
// bitclk toggles, giving a bit period of 2*CLK_DIV clk cycles.
//
// The wrap cycle is reported as a one-clk strobe, split by the current bitclk
// level so the caller knows which bitclk edge lands on the coming clk edge:
//   fall_tick  wrap while bitclk=1  (bitclk falls on the next clk edge)
//   rise_tick  wrap while bitclk=0  (bitclk rises on the next clk edge)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   bitclk     registered bit clock, 0 out of reset
//   rise_tick  strobe, see above
//   fall_tick  strobe, see above
//
// CLK_DIV must be >= 1. The counter carries one spare bit so CLK_DIV=1
// still has a legal, non-overflowing width.
// -----------------------------------------------------------------------------
module serial_bitclk_gen
  import serial_link_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic bitclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int               DIV_W    = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic             bitclk_q;
  logic             bitclk_d;
  logic             wrap;

  always_comb begin
    wrap      = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_cnt_q + DIV_W'(1);
    bitclk_d  = bitclk_q;
    if (wrap) begin
      div_cnt_d = '0;
      bitclk_d  = ~bitclk_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
      bitclk_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bitclk_q  <= bitclk_d;
    end
  end

  assign bitclk    = bitclk_q;
  assign rise_tick = wrap & ~bitclk_q;
  assign fall_tick = wrap &  bitclk_q;

endmodule

// File: rtl/serial_word_transmitter.sv
// -----------------------------------------------------------------------------
// serial_word_transmitter
//
// Transmit end of the 32-bit serial word link. A word accepted on the
// parallel handshake is sent MSB-first on dataout, framed by comEn, with
// every data/frame change placed on the clk edge where bitclk falls. The
// receiver samples on bitclk rising edges, half a bit period later, so each
// bit is stable around its sampling point.
//
// Frame sequence (state names from serial_link_pkg):
//   IDLE   txready=1; a handshake latches txdata and moves to SETUP.
//   SETUP  wait for the next bitclk fall, then raise comEn with the MSB.
//   SHIFT  on each bitclk fall present the next bit; after the last bit drop
//          comEn, pulse done for one clk and move to GAP.
//   GAP    hold comEn low so the receiver clears, then return to IDLE.
// abort in SETUP/SHIFT drops comEn/dataout on the next clk and goes to GAP
// without a done pulse.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   tx_if    parallel request channel (slave modport): txdata, txvalid,
//            txready, abort
//   dataout  serial data, MSB first (registered)
//   comEn    frame enable, high for exactly WORD_W bit periods per complete
//            frame (registered)
//   bitclk   free-running bit clock, period 2*CLK_DIV clk (registered)
//   done     one-clk pulse on normal frame completion (registered)
//   dbg      FSM state and divider strobes, for observation only
// -----------------------------------------------------------------------------
module serial_word_transmitter
  import serial_link_pkg::*;
#(
  parameter int WORD_W   = WORD_W_DEF,
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int GAP_BITS = GAP_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_word_transmitter_if.slave tx_if,
  output logic                    dataout,
  output logic                    comEn,
  output logic                    bitclk,
  output logic                    done,
  output tx_dbg_t                 dbg
);

  localparam int               BCW      = $clog2(WORD_W);
  localparam int               GCW      = $clog2(GAP_BITS + 1) + 1;
  localparam logic [BCW-1:0]   BIT_LAST = BCW'(WORD_W - 1);
  localparam logic [GCW-1:0]   GAP_LAST = GCW'(GAP_BITS - 1);
  localparam logic [GCW-1:0]   GAP_FULL = GCW'(GAP_BITS);

  // ---------------------------------------------------------------------------
  // Bit timing
  // ---------------------------------------------------------------------------
  logic rise_tick;
  logic fall_tick;

  serial_bitclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bitclk_gen (
    .clk       (clk),
    .reset     (reset),
    .bitclk    (bitclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  tx_state_e         state_q,   state_d;
  logic [WORD_W-1:0] shift_q,   shift_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GCW-1:0]    gap_cnt_q, gap_cnt_d;
  logic              txready_q, txready_d;
  logic              dataout_q, dataout_d;
  logic              comen_q,   comen_d;
  logic              done_q,    done_d;

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    txready_d = txready_q;
    dataout_d = dataout_q;
    comen_d   = comen_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // abort has no meaning here, and a capture always wins over it.
        txready_d = 1'b1;
        if (tx_if.txvalid && txready_q) begin
          shift_d   = tx_if.txdata;
          txready_d = 1'b0;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        if (tx_if.abort) begin
          comen_d   = 1'b0;
          dataout_d = 1'b0;
          gap_cnt_d = '0;
          state_d   = GAP;
        end else if (fall_tick) begin
          comen_d   = 1'b1;
          dataout_d = shift_q[WORD_W-1];
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (tx_if.abort) begin
          comen_d   = 1'b0;
          dataout_d = 1'b0;
          gap_cnt_d = '0;
          state_d   = GAP;
        end else if (fall_tick) begin
          if (bit_cnt_q != BIT_LAST) begin
            // The MSB is already on the line, so the next bit to show is
            // the one just below it before the shift.
            shift_d   = shift_q << 1;
            dataout_d = shift_q[WORD_W-2];
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end else begin
            comen_d   = 1'b0;
            dataout_d = 1'b0;
            done_d    = 1'b1;
            // The fall that ends the frame already counts as the first gap
            // bit boundary; an aborted frame starts its gap count from zero
            // because it leaves mid-bit.
            gap_cnt_d = GCW'(1);
            state_d   = GAP;
          end
        end
      end

      GAP: begin
        // Leaving on the last counted fall lets a waiting word be captured
        // and reach SETUP in time for the very next fall, so back-to-back
        // frames see comEn low for exactly GAP_BITS bit periods.
        if (gap_cnt_q >= GAP_FULL) begin
          txready_d = 1'b1;
          state_d   = IDLE;
        end else if (fall_tick) begin
          if (gap_cnt_q == GAP_LAST) begin
            txready_d = 1'b1;
            state_d   = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + GCW'(1);
          end
        end
      end

      default: begin
        comen_d   = 1'b0;
        dataout_d = 1'b0;
        txready_d = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      txready_q <= 1'b1;
      dataout_q <= 1'b0;
      comen_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      txready_q <= txready_d;
      dataout_q <= dataout_d;
      comen_q   <= comen_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tx_if.txready = txready_q;
  assign dataout       = dataout_q;
  assign comEn         = comen_q;
  assign done          = done_q;
  assign dbg           = '{state: state_q, rise_tick: rise_tick, fall_tick: fall_tick};

endmodule

// File: tb/tb_serial_word_transmitter.sv
// -----------------------------------------------------------------------------
// tb_serial_word_transmitter
//
// Two transmitters share clk/reset: dut_a with CLK_DIV=2 (bit period 4 clk)
// and dut_b with CLK_DIV=1 (bit period 2 clk). Each has a small reference
// receiver sampling dataout on bitclk rising edges while comEn is high.
// -----------------------------------------------------------------------------
module tb_serial_word_transmitter;
  import serial_link_pkg::*;

  localparam int W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  serial_word_transmitter_if #(.WORD_W(W)) a_if ();
  serial_word_transmitter_if #(.WORD_W(W)) b_if ();

  logic    a_dataout, a_comen, a_bitclk, a_done;
  logic    b_dataout, b_comen, b_bitclk, b_done;
  tx_dbg_t a_dbg, b_dbg;

  serial_word_transmitter #(.WORD_W(W), .CLK_DIV(2), .GAP_BITS(2)) dut_a (
    .clk(clk), .reset(reset), .tx_if(a_if),
    .dataout(a_dataout), .comEn(a_comen), .bitclk(a_bitclk), .done(a_done), .dbg(a_dbg)
  );

  serial_word_transmitter #(.WORD_W(W), .CLK_DIV(1), .GAP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .tx_if(b_if),
    .dataout(b_dataout), .comEn(b_comen), .bitclk(b_bitclk), .done(b_done), .dbg(b_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------------------------------------------------------------------
  // Reference receivers (sample at negedge, away from the active edge)
  // ---------------------------------------------------------------------------
  int         a_frames = 0, a_done_cnt = 0, a_rx_bits = 0, a_high_run = 0;
  int         a_low_run = 0, a_gap_low = 0, a_last_bits = 0, a_last_high = 0;
  logic [W-1:0] a_rx_shift = '0, a_last_word = '0;
  logic       a_prev_comen = 1'b0, a_prev_bitclk = 1'b0;

  always @(negedge clk) begin
    if (a_done === 1'b1) a_done_cnt++;
    if (a_comen === 1'b1) begin
      if (!a_prev_comen) begin
        a_rx_bits = 0; a_rx_shift = '0; a_high_run = 0; a_gap_low = a_low_run;
      end
      a_high_run++;
      if (a_bitclk === 1'b1 && a_prev_bitclk === 1'b0) begin
        a_rx_shift = {a_rx_shift[W-2:0], a_dataout};
        a_rx_bits++;
      end
    end else begin
      if (a_prev_comen) begin
        a_frames++; a_last_word = a_rx_shift; a_last_bits = a_rx_bits;
        a_last_high = a_high_run; a_low_run = 0;
      end
      a_low_run++;
    end
    a_prev_comen  = (a_comen === 1'b1);
    a_prev_bitclk = a_bitclk;
  end

  int         b_frames = 0, b_rx_bits = 0, b_high_run = 0, b_ones = 0;
  int         b_last_bits = 0, b_last_high = 0, b_last_ones = 0;
  logic [W-1:0] b_rx_shift = '0, b_last_word = '0;
  logic       b_prev_comen = 1'b0, b_prev_bitclk = 1'b0;

  always @(negedge clk) begin
    if (b_comen === 1'b1) begin
      if (!b_prev_comen) begin
        b_rx_bits = 0; b_rx_shift = '0; b_high_run = 0; b_ones = 0;
      end
      b_high_run++;
      if (b_dataout === 1'b1) b_ones++;
      if (b_bitclk === 1'b1 && b_prev_bitclk === 1'b0) begin
        b_rx_shift = {b_rx_shift[W-2:0], b_dataout};
        b_rx_bits++;
      end
    end else if (b_prev_comen) begin
      b_frames++; b_last_word = b_rx_shift; b_last_bits = b_rx_bits;
      b_last_high = b_high_run; b_last_ones = b_ones;
    end
    b_prev_comen  = (b_comen === 1'b1);
    b_prev_bitclk = b_bitclk;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Presents a word and returns once the capture edge has passed; txvalid is
  // left high so the caller can chain a second word.
  task automatic drive_word_a(input logic [W-1:0] w, output bit ok);
    int n = 0;
    a_if.txdata  = w;
    a_if.txvalid = 1'b1;
    while (a_if.txready !== 1'b1 && n < 3000) begin step(); n++; end
    ok = (a_if.txready === 1'b1);
    step();
  endtask

  task automatic drive_word_b(input logic [W-1:0] w, output bit ok);
    int n = 0;
    b_if.txdata  = w;
    b_if.txvalid = 1'b1;
    while (b_if.txready !== 1'b1 && n < 3000) begin step(); n++; end
    ok = (b_if.txready === 1'b1);
    step();
  endtask

  task automatic wait_a_frames(input int target, output bit ok);
    int n = 0;
    while (a_frames < target && n < 3000) begin step(); n++; end
    ok = (a_frames >= target);
  endtask

  task automatic wait_a_bits(input int bits, output bit ok);
    int n = 0;
    while (!(a_comen === 1'b1 && a_rx_bits == bits) && n < 3000) begin step(); n++; end
    ok = (a_comen === 1'b1 && a_rx_bits == bits);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    a_if.txdata = '0; a_if.txvalid = 1'b0; a_if.abort = 1'b0;
    b_if.txdata = '0; b_if.txvalid = 1'b0; b_if.abort = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    repeat (3) step();
    n_tests++;
    if (a_if.txready !== 1'b1) begin n_fail++; $display("FAIL reset_txready: got %b want 1", a_if.txready); end
    n_tests++;
    if (a_comen !== 1'b0) begin n_fail++; $display("FAIL reset_comen: got %b want 0", a_comen); end
    n_tests++;
    if (a_dataout !== 1'b0) begin n_fail++; $display("FAIL reset_dataout: got %b want 0", a_dataout); end
    n_tests++;
    if (a_bitclk !== 1'b0) begin n_fail++; $display("FAIL reset_bitclk: got %b want 0", a_bitclk); end
    n_tests++;
    if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", a_done); end
    n_tests++;
    if (a_dbg.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", a_dbg.state, IDLE); end
    n_tests++;
    if (b_comen !== 1'b0) begin n_fail++; $display("FAIL reset_b_comen: got %b want 0", b_comen); end
    reset = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single_frame();
    bit ok;
    int f0 = a_frames;
    int d0 = a_done_cnt;
    int lat = 0;
    drive_word_a(32'hA5C30F81, ok);
    a_if.txvalid = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_accept: got txready %b want 1", a_if.txready); end
    while (a_comen !== 1'b1 && lat < 50) begin step(); lat++; end
    n_tests++;
    if (lat < 1 || lat > 4) begin n_fail++; $display("FAIL single_latency: got %0d want 1..4", lat); end
    wait_a_frames(f0 + 1, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d frames want %0d", a_frames, f0 + 1); end
    n_tests++;
    if (a_last_word !== 32'hA5C30F81) begin n_fail++; $display("FAIL single_word: got %h want a5c30f81", a_last_word); end
    n_tests++;
    if (a_last_bits != 32) begin n_fail++; $display("FAIL single_bits: got %0d want 32", a_last_bits); end
    n_tests++;
    if (a_last_high != 128) begin n_fail++; $display("FAIL single_comen_len: got %0d want 128", a_last_high); end
    repeat (3) step();
    n_tests++;
    if (a_done_cnt - d0 != 1) begin n_fail++; $display("FAIL single_done: got %0d pulses want 1", a_done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, ok3;
    int f0 = a_frames;
    int d0 = a_done_cnt;
    drive_word_a(32'h00000001, ok1);
    drive_word_a(32'hFFFFFFFF, ok2);
    a_if.txvalid = 1'b0;
    n_tests++;
    if (!(ok1 && ok2)) begin n_fail++; $display("FAIL b2b_accept: got %b%b want 11", ok1, ok2); end
    n_tests++;
    if (a_frames != f0 + 1 || a_last_word !== 32'h00000001) begin
      n_fail++; $display("FAIL b2b_first_word: got %h (frames %0d) want 00000001 (frames %0d)", a_last_word, a_frames, f0 + 1);
    end
    wait_a_frames(f0 + 2, ok3);
    n_tests++;
    if (!ok3) begin n_fail++; $display("FAIL b2b_timeout: got %0d frames want %0d", a_frames, f0 + 2); end
    n_tests++;
    if (a_last_word !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL b2b_second_word: got %h want ffffffff", a_last_word); end
    n_tests++;
    if (a_gap_low != 8) begin n_fail++; $display("FAIL b2b_gap: got %0d clk want 8", a_gap_low); end
    n_tests++;
    if (a_last_high != 128) begin n_fail++; $display("FAIL b2b_comen_len: got %0d want 128", a_last_high); end
    repeat (3) step();
    n_tests++;
    if (a_done_cnt - d0 != 2) begin n_fail++; $display("FAIL b2b_done: got %0d pulses want 2", a_done_cnt - d0); end
  endtask

  task automatic test_busy_ignored();
    bit ok;
    int f0 = a_frames;
    drive_word_a(32'h3C3C5AA5, ok);
    a_if.txvalid = 1'b0;
    wait_a_bits(5, ok);
    n_tests++;
    if (a_if.txready !== 1'b0 || a_dbg.state !== SHIFT) begin
      n_fail++; $display("FAIL busy_state: got txready %b state %0d want 0 %0d", a_if.txready, a_dbg.state, SHIFT);
    end
    a_if.txdata = 32'h12345678;
    a_if.txvalid = 1'b1;
    step();
    a_if.txvalid = 1'b0;
    a_if.txdata = '0;
    wait_a_frames(f0 + 1, ok);
    n_tests++;
    if (a_last_word !== 32'h3C3C5AA5) begin n_fail++; $display("FAIL busy_word: got %h want 3c3c5aa5", a_last_word); end
    repeat (200) step();
    n_tests++;
    if (a_frames != f0 + 1) begin n_fail++; $display("FAIL busy_extra_frame: got %0d frames want %0d", a_frames, f0 + 1); end
    n_tests++;
    if (a_if.txready !== 1'b1 || a_dbg.state !== IDLE) begin
      n_fail++; $display("FAIL busy_idle: got txready %b state %0d want 1 %0d", a_if.txready, a_dbg.state, IDLE);
    end
  endtask

  task automatic test_abort();
    bit ok;
    int f0 = a_frames;
    int d0 = a_done_cnt;
    int n = 0;
    drive_word_a(32'hDEADBEEF, ok);
    a_if.txvalid = 1'b0;
    wait_a_bits(10, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL abort_reach_bit10: got %0d bits want 10", a_rx_bits); end
    a_if.abort = 1'b1;
    step();
    a_if.abort = 1'b0;
    n_tests++;
    if (a_comen !== 1'b0 || a_dataout !== 1'b0) begin
      n_fail++; $display("FAIL abort_drop: got comEn %b dataout %b want 0 0", a_comen, a_dataout);
    end
    n_tests++;
    if (a_dbg.state !== GAP || a_if.txready !== 1'b0) begin
      n_fail++; $display("FAIL abort_gap: got state %0d txready %b want %0d 0", a_dbg.state, a_if.txready, GAP);
    end
    n_tests++;
    if (a_last_bits != 10 || a_last_word !== 32'h0000037A) begin
      n_fail++; $display("FAIL abort_partial: got %0d bits %h want 10 0000037a", a_last_bits, a_last_word);
    end
    while (a_if.txready !== 1'b1 && n < 50) begin step(); n++; end
    n_tests++;
    if (n < 5 || n > 8) begin n_fail++; $display("FAIL abort_gap_len: got %0d clk want 5..8", n); end
    n_tests++;
    if (a_done_cnt != d0) begin n_fail++; $display("FAIL abort_done: got %0d pulses want 0", a_done_cnt - d0); end
    drive_word_a(32'h0BADF00D, ok);
    a_if.txvalid = 1'b0;
    wait_a_frames(f0 + 2, ok);
    n_tests++;
    if (!ok || a_last_word !== 32'h0BADF00D || a_last_bits != 32) begin
      n_fail++; $display("FAIL abort_next_word: got %h (%0d bits) want 0badf00d (32 bits)", a_last_word, a_last_bits);
    end
    n_tests++;
    if (a_gap_low < 8) begin n_fail++; $display("FAIL abort_next_gap: got %0d clk want >=8", a_gap_low); end
    repeat (3) step();
    n_tests++;
    if (a_done_cnt - d0 != 1) begin n_fail++; $display("FAIL abort_next_done: got %0d pulses want 1", a_done_cnt - d0); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int f1;
    drive_word_a(32'h13579BDF, ok);
    a_if.txvalid = 1'b0;
    wait_a_bits(20, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_reach_bit20: got %0d bits want 20", a_rx_bits); end
    reset = 1'b0;
    #1;
    n_tests++;
    if (a_comen !== 1'b0 || a_dataout !== 1'b0 || a_bitclk !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async: got comEn %b dataout %b bitclk %b want 0 0 0", a_comen, a_dataout, a_bitclk);
    end
    n_tests++;
    if (a_if.txready !== 1'b1 || a_dbg.state !== IDLE) begin
      n_fail++; $display("FAIL rstmid_ready: got txready %b state %0d want 1 %0d", a_if.txready, a_dbg.state, IDLE);
    end
    step();
    reset = 1'b1;
    step();
    f1 = a_frames;
    drive_word_a(32'hCAFEF00D, ok);
    a_if.txvalid = 1'b0;
    wait_a_frames(f1 + 1, ok);
    n_tests++;
    if (!ok || a_last_word !== 32'hCAFEF00D || a_last_bits != 32) begin
      n_fail++; $display("FAIL rstmid_next_word: got %h (%0d bits) want cafef00d (32 bits)", a_last_word, a_last_bits);
    end
    n_tests++;
    if (a_last_high != 128) begin n_fail++; $display("FAIL rstmid_comen_len: got %0d want 128", a_last_high); end
  endtask

  task automatic test_clk_div1();
    bit ok;
    int fb = b_frames;
    int n = 0;
    int stuck = 0;
    logic prev;
    drive_word_b(32'h80000000, ok);
    b_if.txvalid = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL div1_accept: got txready %b want 1", b_if.txready); end
    prev = b_bitclk;
    while (b_frames < fb + 1 && n < 300) begin
      step();
      n++;
      if (b_bitclk === prev) stuck++;
      prev = b_bitclk;
    end
    n_tests++;
    if (b_frames < fb + 1) begin n_fail++; $display("FAIL div1_timeout: got %0d frames want %0d", b_frames, fb + 1); end
    n_tests++;
    if (stuck != 0) begin n_fail++; $display("FAIL div1_toggle: got %0d non-toggling clk want 0", stuck); end
    n_tests++;
    if (b_last_word !== 32'h80000000 || b_last_bits != 32) begin
      n_fail++; $display("FAIL div1_word: got %h (%0d bits) want 80000000 (32 bits)", b_last_word, b_last_bits);
    end
    n_tests++;
    if (b_last_high != 64) begin n_fail++; $display("FAIL div1_comen_len: got %0d want 64", b_last_high); end
    n_tests++;
    if (b_last_ones != 2) begin n_fail++; $display("FAIL div1_dataout_high: got %0d clk want 2", b_last_ones); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_busy_ignored();
    test_abort();
    test_reset_mid_frame();
    test_clk_div1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500us want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_word_transmitter.md
Name: serial_word_transmitter

Overview:
Transmit end of the team's 32-bit serial word link. Accepts a parallel word over a valid/ready handshake and serializes it MSB-first on dataout. comEn frames the word, and bitclk is derived from clk by the same half-period divide scheme the receive side uses. Sits between the order/exchange logic and the board-to-board link; it feeds the matching receiver, which samples on bitclk rising edges while comEn is high and flags dataRDY after 32 bits.

Parameters:
WORD_W, 32, bits per frame; must match the receiver.
CLK_DIV, 50, clk cycles per bitclk half-period; bit period = 2*CLK_DIV clk cycles; must be >= 1.
GAP_BITS, 2, bit periods comEn is held low between frames so the receiver clears; must be >= 1.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
txdata  input  WORD_W  word to send; sampled only on the handshake cycle.
txvalid  input  1  word-available request.
txready  output  1  high when a word can be accepted.
abort  input  1  synchronous frame abort.
dataout  output  1  serial data, MSB first.
comEn  output  1  frame enable; high for exactly WORD_W bit periods per complete frame.
bitclk  output  1  free-running bit clock, period 2*CLK_DIV clk cycles.
done  output  1  one-clk pulse when a frame completes normally.

Behaviour:
- Reset (reset=0, async): state IDLE, div_cnt=0, bitclk=0, dataout=0, comEn=0, txready=1, done=0, shift register=0, bit counter=0. All outputs are registered.
- Divider: div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and bitclk toggles. It runs in every state.
- Divider ticks: fall_tick = wrap while bitclk=1. rise_tick = wrap while bitclk=0.
- Handshake: capture occurs on a cycle with txvalid=1 and txready=1. On that cycle, latch txdata, drive txready=0 next cycle, and go to SETUP. txvalid is ignored while txready=0.
- SETUP: wait for the next fall_tick. On that tick, comEn=1, dataout=word[WORD_W-1], bit counter=0, go to SHIFT.
- Capture-to-comEn latency: 1 to 2*CLK_DIV clk cycles.
- SHIFT, each fall_tick:
  - bit counter < WORD_W-1: shift left, dataout = next bit, counter++.
  - bit counter = WORD_W-1: comEn=0, dataout=0, done=1 for that single clk cycle, go to GAP.
  - dataout and comEn change on the same clk edge as bitclk falling, so each bit is stable across the following rising edge.
- GAP: hold comEn=0 for GAP_BITS fall_ticks. Then go to IDLE and set txready=1.
- Back-to-back: a word presented in the same cycle txready returns to 1 is accepted. The minimum comEn-low time between frames is GAP_BITS bit periods.
- abort=1 in SETUP or SHIFT: next clk, comEn=0, dataout=0, done stays 0, go to GAP. The partial frame is discarded by the receiver.
- abort in IDLE or GAP: no effect.
- abort on the capture cycle: the capture still occurs, and the abort is ignored.
- Reset mid-frame: comEn and dataout drop immediately (async). The in-flight word is lost and txready=1 after release.
- Bit counter is $clog2(WORD_W) bits wide. div_cnt is $clog2(CLK_DIV)+1 bits wide (no overflow at CLK_DIV=1).

Decomposition:
- Shared package serial_link_pkg:
  - state enum {IDLE, SETUP, SHIFT, GAP}
  - WORD_W and CLK_DIV defaults, shared with the receiver
- Sub-module serial_bitclk_gen (CLK_DIV):
  - inputs: clk, reset
  - outputs: bitclk, rise_tick, fall_tick
  - reusable by the receiver so both ends agree on bit timing.
- The top holds the FSM, shift register, bit and gap counters, and handshake.

Test Plan:
1. CLK_DIV=2, send 0xA5C30F81 → dataout MSB-first 1010_0101_1100_0011_0000_1111_1000_0001; comEn high exactly 128 clk cycles; one done pulse; a reference receiver sampling on bitclk rise captures 0xA5C30F81.
2. Back-to-back: 0x00000001 then 0xFFFFFFFF with txvalid held → second captured when txready rises; comEn low for exactly GAP_BITS*4 clk cycles between frames; both words recovered.
3. txvalid pulsed with 0x12345678 during SHIFT of the first frame → ignored; txready=0; only the first word is transmitted.
4. abort asserted after 10 bits of 0xDEADBEEF → comEn falls next clk, no done pulse, GAP entered, txready=1 after GAP_BITS periods; the next word 0x0BADF00D is sent intact.
5. reset=0 asserted mid-SHIFT (bit 20) → comEn, dataout, bitclk go 0 with no clk edge, txready=1; after release, 0xCAFEF00D is transmitted correctly.
6. CLK_DIV=1 corner: send 0x80000000 → bitclk toggles every clk; dataout=1 for the first 2-clk bit period only; comEn high 64 clk cycles.
